sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock synchronous FIFO. Default geometry: 8 entries of 32 bits.
- Sits between a producer and a consumer in the same clock domain.
- Gives level status: full, empty and data_count.
- Gives per-request handshake pulses: ack on an accepted request, err on a rejected one.

Parameters:
- DATA_WIDTH, 32, width of d_in/d_out.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8.
- data_count width is ADDR_WIDTH+1 (4 bits, range 0..8).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- rd_en  input  1  read request, sampled each rising edge.
- wr_en  input  1  write request, sampled each rising edge.
- d_in  input  DATA_WIDTH  write data.
- d_out  output  DATA_WIDTH  registered read data.
- data_count  output  ADDR_WIDTH+1  number of stored entries.
- full  output  1  data_count == 8.
- empty  output  1  data_count == 0.
- wr_ack  output  1  one-cycle pulse: the write was accepted.
- wr_err  output  1  one-cycle pulse: the write was rejected (FIFO full).
- rd_ack  output  1  one-cycle pulse: the read was accepted.
- rd_err  output  1  one-cycle pulse: the read was rejected (FIFO empty).

Behaviour:
- Reset (reset=1 at a rising edge):
  - head, tail and data_count go to 0.
  - d_out, wr_ack, wr_err, rd_ack, rd_err go to 0.
  - Memory contents are don't-care.
  - Reset overrides any rd_en/wr_en in the same cycle.
  - Reset mid-operation discards all stored data; empty=1 from the next cycle.
- full and empty are combinational decodes of data_count.
- Accept/reject decisions use the state before the edge:
  - write_ok = wr_en & !full
  - read_ok = rd_en & !empty
- Accepted write: mem[tail] <= d_in; tail increments modulo 8; wr_ack=1 for one cycle.
- Rejected write (wr_en & full): no state change; wr_err=1 for one cycle.
- Accepted read: d_out <= mem[head] at that edge (one-edge latency); head increments modulo 8; rd_ack=1 for one cycle.
- Rejected read (rd_en & empty): d_out holds its value; rd_err=1 for one cycle.
- When no read is accepted, d_out holds its last value.
- data_count next value:
  - +1 if write_ok & !read_ok
  - -1 if read_ok & !write_ok
  - unchanged otherwise
- Simultaneous rd_en & wr_en:
  - Neither full nor empty: both proceed; count unchanged; wr_ack and rd_ack both pulse.
  - Empty: the write proceeds and the read is rejected (rd_err, wr_ack); count goes 0 -> 1. No write-through to d_out.
  - Full: the read proceeds and the write is rejected (rd_ack, wr_err); count goes 8 -> 7.
- Idle cycles (no rd_en, no wr_en): all four handshake outputs are 0.
- Pointers wrap from 7 to 0 with no gap. FIFO order is preserved across wrap.

Optional Feature:
- Macro FIFO_ALMOST_FLAGS_EN.
- When defined:
  - Adds output almost_full (1 bit) = (data_count >= 7).
  - Adds output almost_empty (1 bit) = (data_count <= 1).
  - Both are combinational and are 0/1 respectively after reset.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold reset=1 for 2 edges, release -> empty=1, full=0, data_count=0, d_out=0, all ack/err=0.
- Read from empty:
  - rd_en=1 for 1 cycle after reset -> rd_err=1 for one cycle, rd_ack=0, d_out stays 0, count stays 0.
- Fill past full:
  - Write 0x1..0xB on 11 consecutive cycles.
  - Writes 1-8 -> wr_ack each; count goes 1..8; full=1 after the 8th.
  - Writes 9-11 -> wr_err each; count stays 8.
- Drain past empty:
  - Then rd_en=1 for 12 cycles.
  - Reads 1-8 -> d_out 0x1..0x8 in order with rd_ack; count goes 7..0; empty=1 after the 8th.
  - Reads 9-12 -> rd_err; d_out holds 0x8.
- Wrap-around:
  - Write 5, read 5, then write 6, read 6 (pointers wrap).
  - -> Second batch reads back in exact order; count returns to 0.
- Simultaneous read and write:
  - With count=3, rd_en=wr_en=1 for 4 cycles -> count stays 3; wr_ack and rd_ack both pulse every cycle.
  - With empty and both high -> wr_ack=1, rd_err=1, count=1.
  - With full and both high -> rd_ack=1, wr_err=1, count=7.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with level status and per-request ack/err pulses.
// Define FIFO_ALMOST_FLAGS_EN to add the almost_full / almost_empty outputs.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] COUNT_ZERO = '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic                  write_ok;
    logic                  read_ok;

    assign full     = (data_count == COUNT_FULL);
    assign empty    = (data_count == COUNT_ZERO);
    // Decisions use the level before the edge, so a simultaneous request on a
    // full or empty FIFO lets exactly one side through.
    assign write_ok = wr_en & ~full;
    assign read_ok  = rd_en & ~empty;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign almost_full  = (data_count >= (COUNT_FULL - COUNT_ONE));
    assign almost_empty = (data_count <= COUNT_ONE);
`endif

    // NOTE: storage has no reset; its contents are don't-care until written,
    // and leaving it out lets the array map onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[tail] <= d_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            data_count <= '0;
            d_out      <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            wr_ack <= write_ok;
            wr_err <= wr_en & full;
            rd_ack <= read_ok;
            rd_err <= rd_en & empty;

            if (write_ok) begin
                tail <= tail + 1'b1;
            end
            if (read_ok) begin
                d_out <= mem[head];
                head  <= head + 1'b1;
            end

            case ({write_ok, read_ok})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_sync_fifo;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic [DW-1:0] d_out;
    logic [AW:0]   data_count;
    logic          full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic          almost_full, almost_empty;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .d_in       (d_in),
        .d_out      (d_out),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs derived from its size.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit m_wr_ack = 0, m_wr_err = 0, m_rd_ack = 0, m_rd_err = 0;

    always @(posedge clk) begin
        bit was_full, was_empty;
        if (reset) begin
            q.delete();
            m_dout   = '0;
            m_wr_ack = 0;
            m_wr_err = 0;
            m_rd_ack = 0;
            m_rd_err = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_wr_ack  = wr_en && !was_full;
            m_wr_err  = wr_en && was_full;
            m_rd_ack  = rd_en && !was_empty;
            m_rd_err  = rd_en && was_empty;
            if (m_rd_ack) m_dout = q.pop_front();
            if (m_wr_ack) q.push_back(d_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("d_out",      d_out,      m_dout);
            check("data_count", 32'(data_count), q.size());
            check("full",       32'(full),   32'(q.size() == DEPTH));
            check("empty",      32'(empty),  32'(q.size() == 0));
            check("wr_ack",     32'(wr_ack), 32'(m_wr_ack));
            check("wr_err",     32'(wr_err), 32'(m_wr_err));
            check("rd_ack",     32'(rd_ack), 32'(m_rd_ack));
            check("rd_err",     32'(rd_err), 32'(m_rd_err));
`ifdef FIFO_ALMOST_FLAGS_EN
            check("almost_full",  32'(almost_full),  32'(q.size() >= DEPTH - 1));
            check("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
`endif
        end
    end

    // Drive one cycle of requests at a falling edge; return at the next falling
    // edge, when the outputs of the consuming rising edge are settled.
    task automatic cyc(input bit r, input bit w, input logic [DW-1:0] d);
        rd_en = r;
        wr_en = w;
        d_in  = d;
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic handshakes(input string tag, input bit wa, input bit we, input bit ra, input bit re);
        check({tag, ".wr_ack"}, 32'(wr_ack), 32'(wa));
        check({tag, ".wr_err"}, 32'(wr_err), 32'(we));
        check({tag, ".rd_ack"}, 32'(rd_ack), 32'(ra));
        check({tag, ".rd_err"}, 32'(rd_err), 32'(re));
    endtask

    initial begin
        // Reset held for two edges, then one idle cycle.
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        cyc(0, 0, '0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full",  32'(full),  32'd0);
        check("rst.count", 32'(data_count), 32'd0);
        check("rst.d_out", d_out, 32'h0);
        handshakes("rst", 0, 0, 0, 0);

        // Read from empty.
        cyc(1, 0, '0);
        handshakes("rd_empty", 0, 0, 0, 1);
        check("rd_empty.d_out", d_out, 32'h0);
        check("rd_empty.count", 32'(data_count), 32'd0);
        cyc(0, 0, '0);
        handshakes("rd_empty.after", 0, 0, 0, 0);

        // Fill past full: 0x1..0xB.
        for (int i = 1; i <= 11; i++) begin
            cyc(0, 1, DW'(i));
            if (i <= 8) begin
                handshakes("fill.ok", 1, 0, 0, 0);
                check("fill.count", 32'(data_count), 32'(i));
            end else begin
                handshakes("fill.rej", 0, 1, 0, 0);
                check("fill.count_full", 32'(data_count), 32'd8);
            end
        end
        check("fill.full", 32'(full), 32'd1);

        // Drain past empty.
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 0, '0);
            if (i <= 8) begin
                handshakes("drain.ok", 0, 0, 1, 0);
                check("drain.d_out", d_out, 32'(i));
                check("drain.count", 32'(data_count), 32'(8 - i));
            end else begin
                handshakes("drain.rej", 0, 0, 0, 1);
                check("drain.d_out_hold", d_out, 32'h8);
            end
        end
        check("drain.empty", 32'(empty), 32'd1);

        // Wrap-around: pointers sit at 0 here; 5 then 6 entries cross index 7.
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'h100 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, '0);
            check("wrap1.d_out", d_out, 32'h100 + 32'(i));
        end
        for (int i = 0; i < 6; i++) cyc(0, 1, 32'h200 + 32'(i));
        check("wrap2.count_mid", 32'(data_count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, '0);
            check("wrap2.d_out", d_out, 32'h200 + 32'(i));
        end
        check("wrap2.count", 32'(data_count), 32'd0);

        // Simultaneous read and write at count=3.
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h300 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 32'h400 + 32'(i));
            handshakes("both.mid", 1, 0, 1, 0);
            check("both.count", 32'(data_count), 32'd3);
            check("both.d_out", d_out, (i < 3) ? 32'h300 + 32'(i) : 32'h400);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0, '0);
            check("both.drain", d_out, 32'h400 + 32'(i));
        end

        // Simultaneous on empty: write wins, no write-through.
        cyc(1, 1, 32'h55);
        handshakes("both.empty", 1, 0, 0, 1);
        check("both.empty.count", 32'(data_count), 32'd1);
        check("both.empty.d_out", d_out, 32'h403);

        // Simultaneous on full: read wins.
        for (int i = 1; i < 8; i++) cyc(0, 1, 32'h60 + 32'(i));
        check("both.full.pre", 32'(full), 32'd1);
        cyc(1, 1, 32'hDEAD);
        handshakes("both.full", 0, 1, 1, 0);
        check("both.full.count", 32'(data_count), 32'd7);
        check("both.full.d_out", d_out, 32'h55);

        // Reset mid-operation overrides requests and discards contents.
        reset = 1'b1;
        cyc(1, 1, 32'hBEEF);
        reset = 1'b0;
        check("midrst.empty", 32'(empty), 32'd1);
        check("midrst.count", 32'(data_count), 32'd0);
        check("midrst.d_out", d_out, 32'h0);
        handshakes("midrst", 0, 0, 0, 0);
        cyc(0, 1, 32'h77);
        cyc(1, 0, '0);
        check("midrst.readback", d_out, 32'h77);
        cyc(0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
